// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the fetch unit and decode.
//   Sends the current PC to instruction memory, tracks in-order responses in a
//   DEPTH-entry reservation queue and hands {pc, inst} pairs to decode.
//   Ports: clock/reset (async, active-high); io_pc, io_flush, io_stall_en to the
//   fetch unit; io_imem_req_* / io_imem_resp_* to instruction memory;
//   io_dec_* valid/ready handshake to decode.
//   Optional macro FETCH_QUEUE_BYPASS_EN: a response for an unfilled head is
//   forwarded to decode in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] io_pc,
    input  logic            io_flush,
    output logic            io_stall_en,
    output logic            io_imem_req_valid,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_req_ready,
    input  logic            io_imem_resp_valid,
    input  logic [XLEN-1:0] io_imem_resp_data,
    output logic            io_dec_valid,
    output logic [XLEN-1:0] io_dec_inst,
    output logic [XLEN-1:0] io_dec_pc,
    input  logic            io_dec_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]   head_q, head_d, fill_q, fill_d, alloc_q, alloc_d, drop_q, drop_d;
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] pc_d [DEPTH];
    logic [XLEN-1:0] inst_q [DEPTH];
    logic [XLEN-1:0] inst_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]   occ;
    logic [AW-1:0]   hi, fi, ai;
    logic            req_fire, resp_drop, resp_fill, head_valid, bypass, dec_fire;

    assign occ = alloc_q - head_q;
    assign hi  = head_q[AW-1:0];
    assign fi  = fill_q[AW-1:0];
    assign ai  = alloc_q[AW-1:0];

    // Requests still owed from before a flush count against capacity so the
    // number of outstanding memory requests never exceeds DEPTH.
    assign io_imem_req_addr  = io_pc;
    assign io_imem_req_valid = ~io_flush & (({1'b0, occ} + {1'b0, drop_q}) < (PW+1)'(DEPTH));
    assign req_fire          = io_imem_req_valid & io_imem_req_ready;
    assign io_stall_en       = ~io_flush & ~req_fire;

    assign resp_drop  = io_imem_resp_valid & (drop_q != '0);
    assign resp_fill  = io_imem_resp_valid & (drop_q == '0) & (fill_q != alloc_q);
    assign head_valid = (occ != '0) & filled_q[hi];
`ifdef FETCH_QUEUE_BYPASS_EN
    // fill == head with fill != alloc implies a non-empty queue.
    assign bypass = resp_fill & (fill_q == head_q) & ~filled_q[hi];
`else
    assign bypass = 1'b0;
`endif
    assign io_dec_valid = head_valid | bypass;
    assign io_dec_pc    = io_dec_valid ? pc_q[hi] : '0;
    assign io_dec_inst  = head_valid ? inst_q[hi] : (bypass ? io_imem_resp_data : '0);
    assign dec_fire     = io_dec_valid & io_dec_ready;

    always_comb begin
        head_d   = head_q;
        fill_d   = fill_q;
        alloc_d  = alloc_q;
        drop_d   = drop_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        filled_d = filled_q;
        if (io_flush) begin
            head_d   = '0;
            fill_d   = '0;
            alloc_d  = '0;
            filled_d = '0;
            // Everything requested but unanswered becomes owed; a response
            // arriving now settles one of those debts immediately.
            drop_d   = (alloc_q - fill_q) + drop_q - PW'(resp_drop | resp_fill);
        end else begin
            if (resp_drop)
                drop_d = drop_q - PW'(1);
            if (resp_fill) begin
                inst_d[fi]   = io_imem_resp_data;
                filled_d[fi] = 1'b1;
                fill_d       = fill_q + PW'(1);
            end
            // Clearing after the fill lets a bypassed response retire
            // without leaving its filled bit set.
            if (dec_fire) begin
                filled_d[hi] = 1'b0;
                head_d       = head_q + PW'(1);
            end
            if (req_fire) begin
                pc_d[ai]     = io_pc;
                filled_d[ai] = 1'b0;
                alloc_d      = alloc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            fill_q   <= '0;
            alloc_q  <= '0;
            drop_q   <= '0;
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            fill_q   <= fill_d;
            alloc_q  <= alloc_d;
            drop_q   <= drop_d;
            filled_q <= filled_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue against a queue-based
//   reference model; directed scenarios followed by randomized traffic.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [XLEN-1:0] io_pc = '0;
    logic            io_flush = 1'b0;
    logic            io_imem_req_ready = 1'b0;
    logic            io_imem_resp_valid = 1'b0;
    logic [XLEN-1:0] io_imem_resp_data = '0;
    logic            io_dec_ready = 1'b0;
    logic            io_stall_en, io_imem_req_valid, io_dec_valid;
    logic [XLEN-1:0] io_imem_req_addr, io_dec_inst, io_dec_pc;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .io_pc(io_pc), .io_flush(io_flush),
        .io_stall_en(io_stall_en), .io_imem_req_valid(io_imem_req_valid),
        .io_imem_req_addr(io_imem_req_addr), .io_imem_req_ready(io_imem_req_ready),
        .io_imem_resp_valid(io_imem_resp_valid), .io_imem_resp_data(io_imem_resp_data),
        .io_dec_valid(io_dec_valid), .io_dec_inst(io_dec_inst), .io_dec_pc(io_dec_pc),
        .io_dec_ready(io_dec_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        bit              has;
    } ent_t;

    ent_t q[$];
    int drop_m = 0;
    int memcnt = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic            e_req, e_stall, e_dv;
    logic [XLEN-1:0] e_inst, e_pc;

    task automatic model_eval();
        e_req   = !io_flush && (q.size() + drop_m < DEPTH);
        e_stall = !io_flush && !(e_req && io_imem_req_ready);
        e_dv    = q.size() > 0 && q[0].has;
        e_inst  = e_dv ? q[0].inst : '0;
        e_pc    = e_dv ? q[0].pc : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (!e_dv && q.size() > 0 && drop_m == 0 && io_imem_resp_valid) begin
            e_dv   = 1'b1;
            e_inst = io_imem_resp_data;
            e_pc   = q[0].pc;
        end
`endif
    endtask

    task automatic drive(input logic [XLEN-1:0] pc, input bit fl, input bit rdy,
                         input bit rv, input logic [XLEN-1:0] data, input bit dr);
        io_pc              = pc;
        io_flush           = fl;
        io_imem_req_ready  = rdy;
        io_imem_resp_valid = rv && memcnt > 0;
        io_imem_resp_data  = data;
        io_dec_ready       = dr;
        #1;
        model_eval();
    endtask

    task automatic tick();
        bit fr, fd;
        int unf, k;
        fr = e_req && io_imem_req_ready;
        fd = e_dv && io_dec_ready;
        @(posedge clock);
        if (reset) begin
            q.delete();
            drop_m = 0;
            memcnt = 0;
        end else begin
            if (io_imem_resp_valid) memcnt--;
            if (fr) memcnt++;
            if (io_flush) begin
                unf = 0;
                foreach (q[i]) if (!q[i].has) unf++;
                if (io_imem_resp_valid) begin
                    if (drop_m > 0) drop_m--;
                    else if (unf > 0) unf--;
                end
                drop_m += unf;
                q.delete();
            end else begin
                if (io_imem_resp_valid) begin
                    if (drop_m > 0) drop_m--;
                    else begin
                        k = -1;
                        foreach (q[i]) if (k < 0 && !q[i].has) k = i;
                        if (k >= 0) begin
                            q[k].inst = io_imem_resp_data;
                            q[k].has  = 1'b1;
                        end
                    end
                end
                if (fd) void'(q.pop_front());
                if (fr) q.push_back('{pc: io_pc, inst: '0, has: 1'b0});
            end
        end
        #1;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        @(posedge clock);
        q.delete();
        drop_m = 0;
        memcnt = 0;
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        io_imem_req_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({io_dec_valid, io_dec_inst, io_dec_pc} !== {1'b0, 64'h0}) begin
            n_bad++;
            $display("FAIL reset_dec: got v=%0b inst=%h pc=%h want 0/0/0", io_dec_valid, io_dec_inst, io_dec_pc);
        end
        n_cmp++;
        if ({io_imem_req_valid, io_stall_en} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_req: got valid=%0b stall=%0b want 1/1", io_imem_req_valid, io_stall_en);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(32'(4 * i), 1'b0, 1'b1, i > 0, 32'h1000_0000 + 32'(i - 1), 1'b1);
            n_cmp++;
            if (io_stall_en !== 1'b0 || io_imem_req_valid !== 1'b1 || io_imem_req_addr !== io_pc) begin
                n_bad++;
                $display("FAIL stream_req[%0d]: got stall=%0b valid=%0b addr=%h want 0/1/%h", i, io_stall_en, io_imem_req_valid, io_imem_req_addr, io_pc);
            end
            n_cmp++;
            if ({io_dec_valid, io_dec_pc, io_dec_inst} !== {e_dv, e_pc, e_inst}) begin
                n_bad++;
                $display("FAIL stream_dec[%0d]: got v=%0b pc=%h inst=%h want v=%0b pc=%h inst=%h", i, io_dec_valid, io_dec_pc, io_dec_inst, e_dv, e_pc, e_inst);
            end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(i < 4 ? 32'(4 * i) : 32'h40, 1'b0, 1'b1, i >= 1 && i <= 4, 32'h2000_0000 + 32'(i), i == 5);
            n_cmp++;
            if ({io_imem_req_valid, io_stall_en, io_dec_valid, io_dec_pc, io_dec_inst} !== {e_req, e_stall, e_dv, e_pc, e_inst}) begin
                n_bad++;
                $display("FAIL full[%0d]: got req=%0b stall=%0b v=%0b pc=%h inst=%h want req=%0b stall=%0b v=%0b pc=%h inst=%h", i, io_imem_req_valid, io_stall_en, io_dec_valid, io_dec_pc, io_dec_inst, e_req, e_stall, e_dv, e_pc, e_inst);
            end
            if (i == 4 || i == 5) begin
                n_cmp++;
                if (io_imem_req_valid !== 1'b0 || io_stall_en !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_block[%0d]: got valid=%0b stall=%0b want 0/1", i, io_imem_req_valid, io_stall_en);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (io_imem_req_valid !== 1'b1 || io_imem_req_addr !== 32'h40) begin
                    n_bad++;
                    $display("FAIL full_reissue: got valid=%0b addr=%h want 1/00000040", io_imem_req_valid, io_imem_req_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] pcs [7] = '{32'h0, 32'h4, 32'h100, 32'h100, 32'h104, 32'h104, 32'h104};
        bit fls [7] = '{0, 0, 1, 0, 0, 0, 0};
        bit rdys [7] = '{1, 1, 1, 1, 0, 0, 0};
        bit rvs [7] = '{0, 0, 0, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(pcs[i], fls[i], rdys[i], rvs[i], 32'h3000_0000 + 32'(i), 1'b0);
            n_cmp++;
            if ({io_imem_req_valid, io_stall_en, io_dec_valid, io_dec_pc, io_dec_inst} !== {e_req, e_stall, e_dv, e_pc, e_inst}) begin
                n_bad++;
                $display("FAIL flush[%0d]: got req=%0b stall=%0b v=%0b pc=%h inst=%h want req=%0b stall=%0b v=%0b pc=%h inst=%h", i, io_imem_req_valid, io_stall_en, io_dec_valid, io_dec_pc, io_dec_inst, e_req, e_stall, e_dv, e_pc, e_inst);
            end
            tick();
        end
        n_cmp++;
        if ({io_dec_valid, io_dec_pc, io_dec_inst} !== {1'b1, 32'h100, 32'h3000_0005}) begin
            n_bad++;
            $display("FAIL flush_redirect: got v=%0b pc=%h inst=%h want 1/00000100/30000005", io_dec_valid, io_dec_pc, io_dec_inst);
        end
    endtask

    task automatic test_flush_resp();
        logic [XLEN-1:0] pcs [4] = '{32'h300, 32'h400, 32'h400, 32'h404};
        bit fls [4] = '{0, 1, 0, 0};
        bit rdys [4] = '{1, 1, 1, 0};
        bit rvs [4] = '{0, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(pcs[i], fls[i], rdys[i], rvs[i], 32'h4000_0000 + 32'(i), 1'b0);
            n_cmp++;
            if ({io_imem_req_valid, io_stall_en, io_dec_valid, io_dec_pc, io_dec_inst} !== {e_req, e_stall, e_dv, e_pc, e_inst}) begin
                n_bad++;
                $display("FAIL flush_resp[%0d]: got req=%0b stall=%0b v=%0b pc=%h inst=%h want req=%0b stall=%0b v=%0b pc=%h inst=%h", i, io_imem_req_valid, io_stall_en, io_dec_valid, io_dec_pc, io_dec_inst, e_req, e_stall, e_dv, e_pc, e_inst);
            end
            tick();
        end
        n_cmp++;
        if ({io_dec_valid, io_dec_pc, io_dec_inst} !== {1'b1, 32'h400, 32'h4000_0003}) begin
            n_bad++;
            $display("FAIL flush_resp_deliver: got v=%0b pc=%h inst=%h want 1/00000400/40000003", io_dec_valid, io_dec_pc, io_dec_inst);
        end
    endtask

    task automatic test_async_reset();
        bit rdys [4] = '{1, 1, 1, 0};
        bit rvs [4] = '{0, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(32'h500 + 32'(4 * i), 1'b0, rdys[i], rvs[i], 32'h5000_0000 + 32'(i), 1'b0);
            tick();
        end
        drive(32'h600, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        n_cmp++;
        if ({io_dec_valid, io_dec_pc} !== {e_dv, e_pc} || e_dv !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre: got v=%0b pc=%h want v=1 pc=%h", io_dec_valid, io_dec_pc, e_pc);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({io_dec_valid, io_dec_pc, io_dec_inst, io_imem_req_valid} !== {1'b0, 64'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL areset_now: got v=%0b pc=%h inst=%h req=%0b want 0/0/0/1", io_dec_valid, io_dec_pc, io_dec_inst, io_imem_req_valid);
        end
        tick();
        reset = 1'b0;
        drive(32'h700, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        n_cmp++;
        if ({io_imem_req_valid, io_stall_en, io_imem_req_addr, io_dec_valid} !== {1'b1, 1'b0, 32'h700, 1'b0}) begin
            n_bad++;
            $display("FAIL areset_resume: got req=%0b stall=%0b addr=%h v=%0b want 1/0/00000700/0", io_imem_req_valid, io_stall_en, io_imem_req_addr, io_dec_valid);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom & ~32'h3, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 6);
            n_cmp++;
            if ({io_imem_req_valid, io_stall_en, io_imem_req_addr} !== {e_req, e_stall, io_pc}) begin
                n_bad++;
                $display("FAIL rand_req[%0d]: got req=%0b stall=%0b addr=%h want req=%0b stall=%0b addr=%h", i, io_imem_req_valid, io_stall_en, io_imem_req_addr, e_req, e_stall, io_pc);
            end
            n_cmp++;
            if ({io_dec_valid, io_dec_pc, io_dec_inst} !== {e_dv, e_pc, e_inst}) begin
                n_bad++;
                $display("FAIL rand_dec[%0d]: got v=%0b pc=%h inst=%h want v=%0b pc=%h inst=%h", i, io_dec_valid, io_dec_pc, io_dec_inst, e_dv, e_pc, e_inst);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_full();
        test_flush();
        test_flush_resp();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
